fetch_line_unpacker: RTL and testbench

- Fetch-side stage feeding the decoder.
- Issues line-read requests to the memory/data-cache block and captures each returned INW-bit line.
- Streams the line out as individual DATAW-bit instructions over a valid/ready handshake, each tagged with its PC.
- Handles redirects (branch/jump) and reuses the buffered line when the target falls in it.

---
 rtl/fetch_line_unpacker.sv | 148 ++++++++++++++
 tb/tb_fetch_line_unpacker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_unpacker.sv
// Fetch stage: requests memory lines, buffers one line and streams it out
// one instruction per handshake, reusing the buffer on in-line redirects.
module fetch_line_unpacker #(
    parameter int                DATAW           = 16,
    parameter int                INW             = 512,
    parameter int                ADDRW           = 32,
    parameter int                NUMINSTRUCTIONS = INW / DATAW,
    parameter logic [ADDRW-1:0]  RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDRW-1:0]  redirect_pc,
    output logic              mem_req,
    output logic [ADDRW-1:0]  mem_addr,
    input  logic              mem_valid,
    input  logic [INW-1:0]    mem_data,
    output logic              instr_valid,
    output logic [DATAW-1:0]  instr_data,
    output logic [ADDRW-1:0]  instr_pc,
    input  logic              instr_ready
);

    localparam int LB   = $clog2(INW / 8);
    localparam int WB   = $clog2(DATAW / 8);
    localparam int IDXW = LB - WB;
    localparam logic [ADDRW-1:0] STEP      = ADDRW'(DATAW / 8);
    localparam logic [ADDRW-1:0] LINE_MASK = ~ADDRW'(INW / 8 - 1);
    localparam logic [ADDRW-1:0] PC_MASK   = ~ADDRW'(1);
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NUMINSTRUCTIONS - 1);

    // Handshake: an instruction transfers on a cycle where instr_valid and
    // instr_ready are both high; while instr_ready is low the data and pc hold.
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, SERVE} state_t;

    state_t             state;
    logic [ADDRW-1:0]   pc;
    logic [INW-1:0]     line_buf;
    logic [ADDRW-1:0]   line_tag;
    logic               buf_valid;

    logic [ADDRW-1:0]   target_pc;
    logic [ADDRW-1:0]   target_line;
    logic               target_hit;
    logic [ADDRW-1:0]   pc_next;
    logic               last_word;

    assign target_pc   = redirect_pc & PC_MASK;
    assign target_line = target_pc & LINE_MASK;
    assign target_hit  = buf_valid && (target_line == line_tag);
    assign pc_next     = pc + STEP;
    assign last_word   = (pc[LB-1:WB] == LAST_IDX);

    function automatic logic [DATAW-1:0] pick(input logic [INW-1:0] line,
                                              input logic [IDXW-1:0] idx);
        return line[int'(idx) * DATAW +: DATAW];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            buf_valid   <= 1'b0;
            line_tag    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else begin
            mem_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= pc & LINE_MASK;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc       <= target_pc;
                        mem_req  <= 1'b1;
                        mem_addr <= target_line;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= target_pc;
                        if (mem_valid) begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= target_line;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_valid) begin
                        line_buf    <= mem_data;
                        line_tag    <= pc & LINE_MASK;
                        buf_valid   <= 1'b1;
                        state       <= SERVE;
                        instr_valid <= 1'b1;
                        instr_data  <= pick(mem_data, pc[LB-1:WB]);
                        instr_pc    <= pc;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc <= target_pc;
                    end
                    // The stale line is dropped; refetch whatever pc is now current.
                    if (mem_valid) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_valid ? target_line : (pc & LINE_MASK);
                    end
                end
                SERVE: begin
                    if (redirect_valid) begin
                        pc <= target_pc;
                        if (target_hit) begin
                            instr_data <= pick(line_buf, target_pc[LB-1:WB]);
                            instr_pc   <= target_pc;
                        end else begin
                            state       <= REQ;
                            instr_valid <= 1'b0;
                            mem_req     <= 1'b1;
                            mem_addr    <= target_line;
                        end
                    end else if (instr_ready) begin
                        pc <= pc_next;
                        if (last_word) begin
                            state       <= REQ;
                            instr_valid <= 1'b0;
                            mem_req     <= 1'b1;
                            mem_addr    <= pc_next & LINE_MASK;
                        end else begin
                            instr_data <= pick(line_buf, pc_next[LB-1:WB]);
                            instr_pc   <= pc_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_line_unpacker.sv
// Directed bench for fetch_line_unpacker with a fixed-latency line memory;
// word at byte address a is 0x1000 + a[16:1].
module tb_fetch_line_unpacker;

    localparam int DATAW = 16;
    localparam int INW   = 512;
    localparam int ADDRW = 32;

    logic              clk;
    logic              rst;
    logic              redirect_valid;
    logic [ADDRW-1:0]  redirect_pc;
    logic              mem_req;
    logic [ADDRW-1:0]  mem_addr;
    logic              mem_valid;
    logic [INW-1:0]    mem_data;
    logic              instr_valid;
    logic [DATAW-1:0]  instr_data;
    logic [ADDRW-1:0]  instr_pc;
    logic              instr_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [ADDRW-1:0] req_q[$];
    int req_cnt;
    logic [ADDRW-1:0] req_addr;
    int mem_cnt;

    fetch_line_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory responder: answers each request a fixed number of cycles later
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        mem_cnt   = 0;
        req_addr  = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            mem_cnt   = 0;
            mem_valid = 1'b0;
        end else begin
            if (mem_req) begin
                mem_cnt  = 3;
                req_addr = mem_addr;
                req_q.push_back(mem_addr);
            end else if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
            end
            mem_valid = (mem_cnt == 1);
            if (mem_cnt == 1) begin
                for (int i = 0; i < INW / DATAW; i++) begin
                    logic [ADDRW-1:0] wa;
                    wa = req_addr + ADDRW'(2 * i);
                    mem_data[i*DATAW +: DATAW] = 16'h1000 + wa[16:1];
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && instr_valid !== 1'b1; k++) step();
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 30 && mem_req !== 1'b1; k++) step();
        check(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic redirect(input logic [ADDRW-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        step();
        step();

        // reset state
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", 32'(instr_data), 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // cold start: single request for line 0, then 32 sequential words
        rst = 1'b0;
        step();
        check("cold_req", 32'(mem_req), 32'd1);
        check("cold_req_addr", mem_addr, 32'h0);
        step();
        check("cold_req_pulse", 32'(mem_req), 32'd0);
        wait_valid("cold_first_valid");
        for (int i = 0; i < 32; i++) begin
            check("cold_valid", 32'(instr_valid), 32'd1);
            check("cold_pc", instr_pc, 32'(2 * i));
            check("cold_data", 32'(instr_data), 32'(16'h1000 + 16'(i)));
            step();
        end
        check("line_end_valid", 32'(instr_valid), 32'd0);
        check("line_end_req", 32'(mem_req), 32'd1);
        check("line_end_addr", mem_addr, 32'h40);
        check("cold_req_count", 32'(req_q.size()), 32'd1);

        // miss redirect while the 0x40 line is outstanding
        step();
        redirect(32'h1002);
        wait_req("drain_req");
        check("drain_req_addr", mem_addr, 32'h1000);
        check("drain_req_count", 32'(req_q.size()), 32'd2);
        wait_valid("drain_valid");
        check("drain_pc", instr_pc, 32'h1002);
        check("drain_data", 32'(instr_data), 32'h1801);

        // backpressure at pc 0x06
        instr_ready = 1'b0;
        redirect(32'h6);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_pc", instr_pc, 32'h6);
            check("bp_data", 32'(instr_data), 32'h1003);
            step();
        end
        instr_ready = 1'b1;
        step();
        check("bp_next_pc", instr_pc, 32'h8);
        check("bp_next_data", 32'(instr_data), 32'h1004);

        // hit redirects: no refetch, same-cycle handshake is void
        req_cnt = req_q.size();
        redirect(32'h4);
        check("hit4_pc", instr_pc, 32'h4);
        check("hit4_data", 32'(instr_data), 32'h1002);
        redirect(32'h31);
        check("hit31_valid", 32'(instr_valid), 32'd1);
        check("hit31_pc", instr_pc, 32'h30);
        check("hit31_data", 32'(instr_data), 32'h1018);
        check("hit31_no_req", 32'(mem_req), 32'd0);
        step();
        check("hit_seq_pc", instr_pc, 32'h32);
        check("hit_seq_data", 32'(instr_data), 32'h1019);
        check("hit_req_count", 32'(req_q.size()), 32'(req_cnt));

        // address wrap at the top of memory
        redirect(32'hFFFF_FFFE);
        wait_req("wrap_req");
        check("wrap_req_addr", mem_addr, 32'hFFFF_FFC0);
        wait_valid("wrap_valid");
        check("wrap_pc", instr_pc, 32'hFFFF_FFFE);
        check("wrap_data", 32'(instr_data), 32'h0FFF);
        step();
        check("wrap_end_valid", 32'(instr_valid), 32'd0);
        check("wrap_next_req", 32'(mem_req), 32'd1);
        check("wrap_next_addr", mem_addr, 32'h0);
        wait_valid("wrap0_valid");
        check("wrap0_pc", instr_pc, 32'h0);
        check("wrap0_data", 32'(instr_data), 32'h1000);
        step();
        step();
        check("pre_rst_pc", instr_pc, 32'h4);

        // mid-stream reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_req", 32'(mem_req), 32'd0);
        check("mrst_pc", instr_pc, 32'h0);
        step();
        check("mrst_restart_req", 32'(mem_req), 32'd1);
        check("mrst_restart_addr", mem_addr, 32'h0);
        wait_valid("mrst_valid_again");
        check("mrst_first_pc", instr_pc, 32'h0);
        check("mrst_first_data", 32'(instr_data), 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
